// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one main-memory port between the I-cache and D-cache miss engines
// Optional round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN (fixed D priority otherwise).
module cache_mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

   state_t            state, state_nx;
   logic              mem_read_nx, mem_write_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] mem_wdata_nx;
   logic              d_req, grant_d, grant_i;

   assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   // last_d = 1 when the D-cache received the most recent grant
   logic last_d, last_d_nx;
   assign grant_d = d_req & (~i_read | ~last_d);
`else
   assign grant_d = d_req;
`endif
   assign grant_i = i_read & ~grant_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d    <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         mem_read  <= mem_read_nx;
         mem_write <= mem_write_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
`ifdef ARB_ROUND_ROBIN_EN
         last_d    <= last_d_nx;
`endif
      end
   end

   always_comb begin
      state_nx     = state;
      mem_read_nx  = mem_read;
      mem_write_nx = mem_write;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      i_ready      = 1'b0;
      d_ready      = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_nx    = last_d;
`endif
      case (state)
         IDLE: begin
            if (grant_d) begin
               // a write-back takes precedence over a read from the same requester
               state_nx     = BUSY_D;
               mem_write_nx = d_write;
               mem_read_nx  = ~d_write;
               mem_addr_nx  = d_addr;
               mem_wdata_nx = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_nx    = 1'b1;
`endif
            end else if (grant_i) begin
               state_nx     = BUSY_I;
               mem_write_nx = 1'b0;
               mem_read_nx  = 1'b1;
               mem_addr_nx  = i_addr;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_nx    = 1'b0;
`endif
            end
         end
         BUSY_I: begin
            if (mem_ready) begin
               i_ready      = 1'b1;
               state_nx     = RELEASE;
               mem_read_nx  = 1'b0;
               mem_write_nx = 1'b0;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               d_ready      = 1'b1;
               state_nx     = RELEASE;
               mem_read_nx  = 1'b0;
               mem_write_nx = 1'b0;
            end
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign i_rdata = i_ready ? mem_rdata : '0;
   assign d_rdata = d_ready ? mem_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         i_grant_cnt <= '0;
         d_grant_cnt <= '0;
      end else begin
         if (i_ready && !(&i_grant_cnt)) i_grant_cnt <= i_grant_cnt + CNT_W'(1);
         if (d_ready && !(&d_grant_cnt)) d_grant_cnt <= d_grant_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter with a latency-programmable memory model
module tb_cache_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst, i_read, d_read, d_write, mem_ready;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
   logic          i_ready, d_ready, mem_read, mem_write;
   logic [CW-1:0] i_grant_cnt, d_grant_cnt;

   always #5 clk = ~clk;

   cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   typedef struct {
      logic          is_write;
      logic          who_d;
      logic          exp_ready;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;
      int            gap;
   } exp_t;

   typedef struct {
      logic          is_i, rd, wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;
      int            icnt, dcnt;
   } vec_t;

   exp_t expq[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   done_total = 0;
   bit   mdl_busy = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total_cnt++;
      if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
      else pass_cnt++;
   endtask

   function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - 28'h0000010;
      return {4{32'hDEADBEEF}} ^ {{(DW-AW){1'b0}}, off};
   endfunction

   function automatic exp_t mk(input logic who_d, input logic is_write, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input int lat, input int gap);
      exp_t e;
      e.who_d = who_d; e.is_write = is_write; e.exp_ready = 1'b1;
      e.addr = a; e.wdata = wd; e.lat = lat; e.gap = gap;
      return e;
   endfunction

   // memory model: checks each new command against the queue head and answers after lat cycles
   initial begin
      exp_t cur;
      int   cnt, cyc, last_fire;
      bit   rel;
      mem_ready = 1'b0;
      mem_rdata = '0;
      cnt = 0; cyc = 0; last_fire = 0; rel = 0;
      cur = mk(1'b0, 1'b0, '0, '0, 1, 0);
      forever begin
         @(negedge clk);
         cyc++;
         mem_ready = 1'b0;
         mem_rdata = {4{32'h5A5AC3C3}};
         #1;
         chk("idle_ready", {126'd0, i_ready, d_ready}, '0);
         chk("idle_rdata", i_rdata | d_rdata, '0);
         if (rel) begin
            chk("release_cmd", {126'd0, mem_read, mem_write}, '0);
            rel = 0;
         end else if (!mdl_busy && (mem_read || mem_write)) begin
            if (expq.size() == 0) begin
               chk("unexpected_cmd", {126'd0, mem_read, mem_write}, '0);
            end else begin
               cur = expq.pop_front();
               chk("cmd_read", {127'd0, mem_read}, {127'd0, !cur.is_write});
               chk("cmd_write", {127'd0, mem_write}, {127'd0, cur.is_write});
               chk("cmd_addr", {100'd0, mem_addr}, {100'd0, cur.addr});
               if (cur.is_write) chk("cmd_wdata", mem_wdata, cur.wdata);
               if (cur.gap != 0) chk("cmd_gap", DW'(cyc - last_fire), DW'(cur.gap));
               mdl_busy = 1;
               cnt = cur.lat;
            end
         end else if (mdl_busy) begin
            cnt--;
            if (cnt == 0) begin
               mem_rdata = rpat(cur.addr);
               mem_ready = 1'b1;
               #1;
               chk("i_ready", {127'd0, i_ready}, {127'd0, cur.exp_ready && !cur.who_d});
               chk("d_ready", {127'd0, d_ready}, {127'd0, cur.exp_ready && cur.who_d});
               chk("i_rdata", i_rdata, (cur.exp_ready && !cur.who_d) ? rpat(cur.addr) : '0);
               chk("d_rdata", d_rdata, (cur.exp_ready && cur.who_d) ? rpat(cur.addr) : '0);
               if (cur.exp_ready) done_total++;
               mdl_busy = 0;
               last_fire = cyc;
               rel = 1;
            end
         end
      end
   end

   task automatic wait_done(input int target);
      int t = 0;
      while (done_total < target && t < 200) begin
         @(negedge clk); #3;
         t++;
      end
      if (done_total < target) chk("wait_done_timeout", DW'(done_total), DW'(target));
   endtask

   task automatic do_reset();
      @(negedge clk); #3;
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic chk_cnt(input string name, input int ic, input int dc);
      chk({name, "_icnt"}, DW'(i_grant_cnt), DW'(ic));
      chk({name, "_dcnt"}, DW'(d_grant_cnt), DW'(dc));
   endtask

   initial begin
      vec_t vt[5];
      exp_t e;
      int   t;
      vt[0] = '{is_i:1, rd:0, wr:0, addr:28'h0000010, wdata:'0, lat:4, icnt:1, dcnt:0};
      vt[1] = '{is_i:0, rd:1, wr:0, addr:28'h0ABCDE0, wdata:'0, lat:2, icnt:1, dcnt:1};
      vt[2] = '{is_i:0, rd:0, wr:1, addr:28'h1234560, wdata:{4{32'hCAFEF00D}}, lat:3, icnt:1, dcnt:2};
      vt[3] = '{is_i:0, rd:1, wr:1, addr:28'h0F0F0F0, wdata:{4{32'h01234567}}, lat:1, icnt:1, dcnt:3};
      vt[4] = '{is_i:1, rd:0, wr:0, addr:28'hFFFFFF0, wdata:'0, lat:5, icnt:2, dcnt:3};

      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      step(3);
      rst = 1'b0;
      chk("reset_mem", {126'd0, mem_read, mem_write}, '0);
      chk("reset_addr", {100'd0, mem_addr}, '0);
      chk("reset_wdata", mem_wdata, '0);
      chk_cnt("reset", 0, 0);

      // single transactions from the vector table
      for (int k = 0; k < 5; k++) begin
         expq.push_back(mk(!vt[k].is_i, !vt[k].is_i && vt[k].wr, vt[k].addr, vt[k].wdata, vt[k].lat, 0));
         if (vt[k].is_i) begin
            i_addr = vt[k].addr; i_read = 1;
         end else begin
            d_addr = vt[k].addr; d_wdata = vt[k].wdata; d_read = vt[k].rd; d_write = vt[k].wr;
         end
         wait_done(k + 1);
         i_read = 0; d_read = 0; d_write = 0;
         step(3);
         chk_cnt("vec", vt[k].icnt, vt[k].dcnt);
      end

      // simultaneous write-back and I read: D first, I issued 3 cycles after the D completion
      do_reset();
      done_total = 0;
      d_addr = 28'h0000400; d_wdata = {4{32'hA5A5F00F}}; i_addr = 28'h0000800;
      expq.push_back(mk(1'b1, 1'b1, d_addr, d_wdata, 3, 0));
      expq.push_back(mk(1'b0, 1'b0, i_addr, '0, 2, 3));
      d_write = 1; i_read = 1;
      wait_done(1);
      step(2);
      d_write = 0;
      wait_done(2);
      i_read = 0;
      step(3);
      chk_cnt("both", 1, 1);

      // both requesters held for four transactions
      do_reset();
      done_total = 0;
      d_addr = 28'h0000C00; i_addr = 28'h0000D00;
`ifdef ARB_ROUND_ROBIN_EN
      expq.push_back(mk(1'b1, 1'b0, d_addr, '0, 2, 0));
      expq.push_back(mk(1'b0, 1'b0, i_addr, '0, 2, 3));
      expq.push_back(mk(1'b1, 1'b0, d_addr, '0, 2, 3));
      expq.push_back(mk(1'b0, 1'b0, i_addr, '0, 2, 3));
`else
      expq.push_back(mk(1'b1, 1'b0, d_addr, '0, 2, 0));
      for (int k = 0; k < 3; k++) expq.push_back(mk(1'b1, 1'b0, d_addr, '0, 2, 3));
`endif
      d_read = 1; i_read = 1;
      wait_done(4);
      d_read = 0; i_read = 0;
      step(4);
`ifdef ARB_ROUND_ROBIN_EN
      chk_cnt("held4", 2, 2);
`else
      chk_cnt("held4", 0, 3);
`endif

      // request held through the release cycle must not be re-granted
      do_reset();
      done_total = 0;
      i_addr = 28'h0000010;
      expq.push_back(mk(1'b0, 1'b0, i_addr, '0, 4, 0));
      i_read = 1;
      wait_done(1);
      step(1);
      chk("hold_release_read", {127'd0, mem_read}, '0);
      step(1);
      i_read = 0;
      step(3);
      chk("hold_no_dup", {127'd0, mem_read}, '0);
      chk_cnt("hold", 1, 0);

      // reset while BUSY_D; the late mem_ready must be ignored
      do_reset();
      done_total = 0;
      d_addr = 28'h0000E00;
      e = mk(1'b1, 1'b0, d_addr, '0, 6, 0);
      e.exp_ready = 1'b0;
      expq.push_back(e);
      d_read = 1;
      t = 0;
      while (!mdl_busy && t < 50) begin step(1); t++; end
      chk("abort_cmd_seen", {127'd0, mdl_busy}, {127'd0, 1'b1});
      step(1);
      rst = 1; d_read = 0;
      step(1);
      rst = 0;
      chk("abort_mem", {126'd0, mem_read, mem_write}, '0);
      chk("abort_addr", {100'd0, mem_addr}, '0);
      t = 0;
      while (mdl_busy && t < 50) begin step(1); t++; end
      chk("abort_model_idle", {127'd0, mdl_busy}, '0);
      step(2);
      chk("abort_mem_after", {126'd0, mem_read, mem_write}, '0);
      chk("abort_wdata", mem_wdata, '0);
      chk_cnt("abort", 0, 0);

      // saturation of the 2-bit I counter
      do_reset();
      done_total = 0;
      for (int k = 1; k <= 5; k++) begin
         i_addr = AW'(k * 16);
         expq.push_back(mk(1'b0, 1'b0, i_addr, '0, 1 + (k % 3), 0));
         i_read = 1;
         wait_done(k);
         i_read = 0;
         step(3);
         chk("sat_icnt", DW'(i_grant_cnt), DW'((k > 3) ? 3 : k));
      end

      chk("queue_empty", DW'(expq.size()), '0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
